adder32_rr_sched: RTL
=====================

Name: adder32_rr_sched

Overview:
- Round-robin scheduler that shares one registered 32-bit signed adder (1-cycle latency, 33-bit internal result truncated to 32 bits) among NREQ requesters in the accelerator datapath.
- Accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the adder through registered operand outputs.
- Tracks the issuing requester through the adder latency, routes each sum back with a per-requester valid strobe, and flags signed overflow, because the adder drops bit 32.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width; must match the adder.
- ADD_LAT, 1, adder latency in cycles from its inputs to its out.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high. The top level drives the shared adder's rst_n from ~rst.
- enable  input  1  when 0, no new grants; in-flight operations still complete.
- req_valid  input  NREQ  requester i has an operand pair.
- req_ready  output  NREQ  one-hot grant; transfer on req_valid[i] & req_ready[i].
- req_a  input  NREQ*W  requester i operand A in bits [i*W +: W], signed.
- req_b  input  NREQ*W  requester i operand B in bits [i*W +: W], signed.
- add_in1  output  W  registered operand A to the adder.
- add_in2  output  W  registered operand B to the adder.
- add_out  input  W  adder result.
- rsp_valid  output  NREQ  one-cycle strobe: rsp_data belongs to requester i.
- rsp_data  output  W  sum, equal to add_out during the strobe.
- rsp_ovf  output  1  signed overflow of the responding operation; 0 when no rsp_valid.
- busy  output  1  any operation issued and not yet responded.

Behaviour:
- Reset: req_ready=0, add_in1=add_in2=0, rsp_valid=0, rsp_ovf=0, busy=0, RR pointer=0, tag pipeline cleared (no stale responses).
- Arbitration, combinational in the same cycle:
  - Search req_valid starting at the pointer index, wrapping modulo NREQ; the first asserted index wins.
  - req_ready is one-hot on the winner, and all zeros if enable=0 or no request is valid.
  - req_ready never asserts without the matching req_valid.
- Pointer update: after a transfer from index g, pointer <= (g+1) mod NREQ. With no transfer the pointer holds.
- Issue stage:
  - On a transfer at edge t, add_in1/add_in2 <= req_a[g]/req_b[g].
  - In cycles with no transfer, add_in1/add_in2 <= 0.
  - Throughput is one operation per cycle with no bubbles.
- Tag pipeline:
  - Depth 1+ADD_LAT; each entry holds {valid, index[clog2(NREQ)-1:0], signA, signB}.
  - The entry is written at the transfer edge and shifts every cycle unconditionally.
  - No backpressure: responders must sink every strobe.
- Response:
  - Cycle latency from the transfer cycle to rsp_valid is 1+ADD_LAT (default 2).
  - rsp_valid[index] = tail.valid.
  - rsp_data = add_out when tail.valid, else 0.
  - rsp_ovf = tail.valid & (signA==signB) & (add_out[W-1]!=signA).
- busy = OR of all tag valid bits; it drops in the cycle after the last rsp_valid.
- Wrap-around: sums are modulo 2^W, with overflow reported only via rsp_ovf.
- Simultaneous events: a new grant and a response for the same requester can occur in the same cycle, and both are legal.
- Reset mid-operation:
  - All in-flight tags are cleared and no rsp_valid fires for them.
  - Requesters must reissue.
  - Pointer returns to 0.
- enable falling mid-stream: in-flight operations still respond on schedule; pointer frozen.

Test Plan:
- Single request, req_valid=4'b0010, a=5, b=7 at cycle 0 -> req_ready=4'b0010 in cycle 0; add_in1=5, add_in2=7 in cycle 1; rsp_valid=4'b0010, rsp_data=12, rsp_ovf=0 in cycle 2; busy high in cycles 1-2 only.
- All four requesters continuously valid, each with A=i, B=100 -> grants 0,1,2,3,0,... with one per cycle; rsp_data sequence 100,101,102,103,100 routed to matching rsp_valid bits; no idle cycles.
- Overflow: a=32'h7FFFFFFF, b=1 -> rsp_data=32'h80000000, rsp_ovf=1. a=32'h80000000, b=32'hFFFFFFFF -> 32'h7FFFFFFF, rsp_ovf=1. a=-3, b=3 -> 0, rsp_ovf=0.
- Fairness: requester 0 always valid, requester 2 pulses valid -> requester 2 granted within NREQ cycles of asserting, and requester 0 is never granted twice in a row while requester 2 waits.
- rst asserted one cycle after two back-to-back grants -> no rsp_valid in following cycles; all outputs 0; first grant after reset goes to lowest valid index from pointer 0.
- enable=0 while requests pending -> req_ready=0; in-flight results still delivered; re-enabling resumes from the saved pointer.

Source files
------------

// File: rtl/adder32_rr_sched.sv
// adder32_rr_sched: round-robin sharing of one registered adder among
// NREQ requesters, with tag tracking, response routing and overflow flag.
module adder32_rr_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      add_in1,
  output logic [W-1:0]      add_in2,
  input  logic [W-1:0]      add_out,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_ovf,
  output logic              busy
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW1   = IW + 1;
  localparam int DEPTH = 1 + ADD_LAT;

  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    logic v;
    idx_t idx;
    logic sa;
    logic sb;
  } tag_t;

  idx_t            ptr_q, ptr_d;
  logic [W-1:0]    in1_q, in1_d;
  logic [W-1:0]    in2_q, in2_d;
  tag_t            tag_q [DEPTH];
  tag_t            tag_d;
  tag_t            tail;
  logic [NREQ-1:0] grant;
  idx_t            gidx;
  logic            found;
  logic [IW1-1:0]  pos;
  logic [W-1:0]    a_sel, b_sel;
  logic            any_v;

  // Search from the pointer, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr_q} + IW1'(k);
      if (pos >= IW1'(NREQ)) begin
        pos = pos - IW1'(NREQ);
      end
      if (!found && !rst && enable && req_valid[pos[IW-1:0]]) begin
        found = 1'b1;
        gidx  = pos[IW-1:0];
      end
    end
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = found && (gidx == idx_t'(i));
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        a_sel = a_sel | req_a[i*W +: W];
        b_sel = b_sel | req_b[i*W +: W];
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    in1_d     = '0;
    in2_d     = '0;
    tag_d     = '0;
    if (found) begin
      ptr_d     = (gidx == idx_t'(NREQ - 1)) ? '0 : gidx + idx_t'(1);
      in1_d     = a_sel;
      in2_d     = b_sel;
      tag_d.v   = 1'b1;
      tag_d.idx = gidx;
      tag_d.sa  = a_sel[W-1];
      tag_d.sb  = b_sel[W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      tag_q[0] <= tag_d;
      for (int i = 1; i < DEPTH; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tail      = tag_q[DEPTH-1];
  assign req_ready = grant;
  assign add_in1   = in1_q;
  assign add_in2   = in2_q;

  // Overflow: like-signed operands whose truncated sum flips sign
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = tail.v && !rst && (tail.idx == idx_t'(i));
    end
    rsp_data = (tail.v && !rst) ? add_out : '0;
    rsp_ovf  = tail.v && !rst && (tail.sa == tail.sb) &&
               (add_out[W-1] != tail.sa);
    any_v    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_v = any_v | tag_q[i].v;
    end
    busy = any_v && !rst;
  end

endmodule
